// File: rtl/midi_message_parser_if.sv
// MIDI message types and the byte-in / message-out bundle of the parser.
// Handshake: byte_in is valid only in a cycle where byte_ready is high; message
// is valid only in the single cycle message_ready is high. Neither direction has
// backpressure, so each strobe is consumed in the cycle it appears.
package MIDI;
   typedef struct packed {
      logic [3:0] message_type;
      logic [6:0] data_byte1;
      logic [6:0] data_byte2;
   } message_t;

   localparam logic [3:0] NOTE_OFF         = 4'h8;
   localparam logic [3:0] NOTE_ON          = 4'h9;
   localparam logic [3:0] POLY_PRESSURE    = 4'hA;
   localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
   localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
   localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
   localparam logic [3:0] PITCH_BEND       = 4'hE;
endpackage

interface midi_message_parser_if;
   logic [7:0]     byte_in;
   logic           byte_ready;
   MIDI::message_t message;
   logic           message_ready;
   logic           sysex_active;
   logic [1:0]     parser_state;   // debug view of the parser state register

   // Byte source / message sink side.
   modport master (
      output byte_in, byte_ready,
      input  message, message_ready, sysex_active, parser_state
   );

   // Parser side.
   modport slave (
      input  byte_in, byte_ready,
      output message, message_ready, sysex_active, parser_state
   );
endinterface

// File: rtl/midi_message_parser.sv
// MIDI channel-voice message parser: running status, realtime pass-over,
// SysEx skipping, channel filter, NOTE_ON velocity 0 -> NOTE_OFF, and a
// timeout that abandons stale partial messages.
module midi_message_parser #(
   parameter int unsigned CHANNEL        = 0,
   parameter int unsigned OMNI           = 1,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                    clock_50_000_000,
   input  logic                    reset,
   midi_message_parser_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_D1 = 2'd1,
      WAIT_D2 = 2'd2,
      SYSEX   = 2'd3
   } state_t;

   // Counter only has to hold TIMEOUT_CYCLES-1: expiry is detected one count early.
   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [3:0] CH = 4'(CHANNEL);

   state_t         state_q, state_d;
   logic           rs_valid_q, rs_valid_d;
   logic [3:0]     rs_type_q, rs_type_d;
   logic [3:0]     rs_chan_q, rs_chan_d;
   logic [6:0]     d1_q, d1_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   MIDI::message_t message_q, message_d;
   logic           ready_q, ready_d;
   logic           sysex_q;

   logic           is_realtime;
   logic           take_d1;
   logic           emit;
   logic [6:0]     em_d1, em_d2;
   logic           accept;

   assign is_realtime = (bus.byte_in[7:3] == 5'b11111);
   assign accept      = (OMNI != 0) || (rs_chan_q == CH);

   // Next-state decode for one received byte, or timeout aging when no byte arrives.
   always_comb begin
      state_d    = state_q;
      rs_valid_d = rs_valid_q;
      rs_type_d  = rs_type_q;
      rs_chan_d  = rs_chan_q;
      d1_d       = d1_q;
      cnt_d      = cnt_q;
      message_d  = message_q;
      ready_d    = 1'b0;
      take_d1    = 1'b0;
      emit       = 1'b0;
      em_d1      = '0;
      em_d2      = '0;

      if (bus.byte_ready && !is_realtime) begin
         cnt_d = '0;
         if (bus.byte_in[7]) begin
            if (bus.byte_in < 8'hF0) begin
               rs_valid_d = 1'b1;
               rs_type_d  = bus.byte_in[7:4];
               rs_chan_d  = bus.byte_in[3:0];
               state_d    = WAIT_D1;
            end else if (bus.byte_in == 8'hF0) begin
               rs_valid_d = 1'b0;
               state_d    = SYSEX;
            end else begin
               rs_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end else begin
            case (state_q)
               IDLE:    take_d1 = rs_valid_q;
               WAIT_D1: take_d1 = 1'b1;
               WAIT_D2: begin
                  emit    = 1'b1;
                  em_d1   = d1_q;
                  em_d2   = bus.byte_in[6:0];
                  state_d = IDLE;
               end
               default: ;   // SysEx payload is discarded
            endcase
            if (take_d1) begin
               if (rs_type_q == MIDI::PROGRAM_CHANGE || rs_type_q == MIDI::CHANNEL_PRESSURE) begin
                  emit    = 1'b1;
                  em_d1   = bus.byte_in[6:0];
                  em_d2   = '0;
                  state_d = IDLE;
               end else begin
                  d1_d    = bus.byte_in[6:0];
                  state_d = WAIT_D2;
               end
            end
         end
      end else if (!bus.byte_ready && TIMEOUT_CYCLES != 0 && state_q != IDLE) begin
         if (cnt_q >= LIMIT) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end

      if (emit && accept) begin
         ready_d                = 1'b1;
         message_d.message_type = rs_type_q;
         message_d.data_byte1   = em_d1;
         message_d.data_byte2   = em_d2;
         if (rs_type_q == MIDI::NOTE_ON && em_d2 == 7'd0) begin
            message_d.message_type = MIDI::NOTE_OFF;
         end
      end
   end

   // State, running status, counter and registered outputs.
   always_ff @(posedge clock_50_000_000) begin
      if (reset) begin
         state_q    <= IDLE;
         rs_valid_q <= 1'b0;
         rs_type_q  <= '0;
         rs_chan_q  <= '0;
         d1_q       <= '0;
         cnt_q      <= '0;
         message_q  <= '0;
         ready_q    <= 1'b0;
         sysex_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rs_valid_q <= rs_valid_d;
         rs_type_q  <= rs_type_d;
         rs_chan_q  <= rs_chan_d;
         d1_q       <= d1_d;
         cnt_q      <= cnt_d;
         message_q  <= message_d;
         ready_q    <= ready_d;
         sysex_q    <= (state_d == SYSEX);
      end
   end

   assign bus.message       = message_q;
   assign bus.message_ready = ready_q;
   assign bus.sysex_active  = sysex_q;
   assign bus.parser_state  = state_q;

endmodule

// File: tb/tb_midi_message_parser.sv
// Randomized self-checking bench for midi_message_parser with a queue-based
// reference model and a separate monitor comparing every DUT output cycle.
module tb_midi_message_parser;

   localparam int unsigned T_CHANNEL = 2;
   localparam int unsigned T_OMNI    = 0;
   localparam int unsigned T_TIMEOUT = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   midi_message_parser_if bus();

   midi_message_parser #(
      .CHANNEL(T_CHANNEL), .OMNI(T_OMNI), .TIMEOUT_CYCLES(T_TIMEOUT)
   ) dut (
      .clock_50_000_000(clk),
      .reset(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Scoreboard state
   logic [17:0] exp_q[$];
   int          exp_cyc_q[$];
   logic        exp_sx_q[$];
   logic [17:0] last_msg;
   bit          armed = 0;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   // Reference model: message-level view of the stream
   bit          m_rs_valid;
   logic [3:0]  m_type;
   logic [3:0]  m_chan;
   logic [6:0]  m_pend[$];
   bit          m_mid;     // a channel message is partly received
   bit          m_sysex;
   int          m_idle;

   task automatic model_reset();
      m_rs_valid = 0; m_type = 0; m_chan = 0;
      m_pend.delete(); m_mid = 0; m_sysex = 0; m_idle = 0;
   endtask

   task automatic model_emit();
      logic [3:0] t;
      logic [6:0] a, b;
      t = m_type;
      a = m_pend[0];
      b = (m_pend.size() > 1) ? m_pend[1] : 7'd0;
      if (t == 4'h9 && b == 0) t = 4'h8;
      if (T_OMNI != 0 || m_chan == 4'(T_CHANNEL)) begin
         exp_q.push_back({t, a, b});
         exp_cyc_q.push_back(cyc + 1);
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      int need;
      if (b >= 8'hF8) return;
      m_idle = 0;
      if (b >= 8'h80 && b <= 8'hEF) begin
         m_rs_valid = 1; m_type = b[7:4]; m_chan = b[3:0];
         m_pend.delete(); m_mid = 1; m_sysex = 0;
      end else if (b >= 8'hF0) begin
         m_rs_valid = 0; m_pend.delete(); m_mid = 0;
         m_sysex = (b == 8'hF0);
      end else if (!m_sysex && m_rs_valid) begin
         m_pend.push_back(b[6:0]);
         need = (m_type == 4'hC || m_type == 4'hD) ? 1 : 2;
         if (m_pend.size() == need) begin
            model_emit();
            m_pend.delete();
            m_mid = 0;
         end else begin
            m_mid = 1;
         end
      end
   endtask

   task automatic model_idle();
      if (T_TIMEOUT != 0 && (m_mid || m_sysex)) begin
         m_idle++;
         if (m_idle >= T_TIMEOUT) begin
            m_mid = 0; m_sysex = 0; m_pend.delete(); m_idle = 0;
         end
      end
   endtask

   // Driver: one cycle of stimulus, model advanced to the state after the edge
   task automatic step(input bit r, input bit v, input logic [7:0] b);
      @(negedge clk);
      rst = r;
      bus.byte_ready = v;
      bus.byte_in = v ? b : 8'($urandom_range(0, 255));
      if (r) begin
         model_reset();
         last_msg = '0;
         armed = 1;
      end else if (v) begin
         model_byte(b);
      end else begin
         model_idle();
      end
      exp_sx_q.push_back(m_sysex);
   endtask

   task automatic send(input logic [7:0] b);
      step(0, 1, b);
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 8'h00);
   endtask

   // Monitor: compare DUT outputs against the scoreboard every cycle
   always @(posedge clk) begin
      logic [17:0] e;
      int ec;
      logic es;
      #1;
      cyc++;
      if (exp_sx_q.size() > 0) begin
         es = exp_sx_q.pop_front();
         checks++;
         if (bus.sysex_active !== es) begin
            errors++;
            $display("FAIL sysex_active cyc=%0d got=%b exp=%b", cyc, bus.sysex_active, es);
         end
      end
      if (armed) begin
         checks++;
         if (bus.message_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe cyc=%0d got=%h exp=none", cyc, bus.message);
            end else begin
               e  = exp_q.pop_front();
               ec = exp_cyc_q.pop_front();
               if (bus.message !== e || cyc != ec) begin
                  errors++;
                  $display("FAIL message cyc=%0d got=%h exp=%h at cyc %0d", cyc, bus.message, e, ec);
               end
               last_msg = e;
            end
         end else if (bus.message_ready !== 1'b0 || bus.message !== last_msg) begin
            errors++;
            $display("FAIL message_hold cyc=%0d got=%h rdy=%b exp=%h rdy=0", cyc, bus.message,
                     bus.message_ready, last_msg);
         end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            errors++;
            $display("FAIL missing_strobe cyc=%0d got=none exp=%h", cyc, exp_q[0]);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
         end
      end
   end

   initial begin
      int r;
      logic [3:0] ch;
      bus.byte_ready = 0;
      bus.byte_in = 0;
      model_reset();
      last_msg = '0;
      repeat (2) @(negedge clk);
      // reset, with a byte in the same cycle that must be lost
      step(1, 0, 8'h00);
      step(1, 1, 8'h92);
      idle(2);
      // basic note on
      send(8'h92); send(8'h3C); send(8'h64); idle(3);
      // running status with velocity-0 note on
      send(8'h92); send(8'h3C); send(8'h64); send(8'h3E); send(8'h00); idle(2);
      // realtime interleave
      send(8'hB2); send(8'hF8); send(8'h40); send(8'hFE); send(8'h7F); idle(2);
      // one-byte type and SysEx
      send(8'hC2); send(8'h05); idle(1);
      send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h10); idle(2);
      // channel filter
      send(8'h91); send(8'h3C); send(8'h64); send(8'h92); send(8'h3C); send(8'h64); idle(2);
      // timeout abandons stale D1, keeps running status
      send(8'h92); send(8'h3C); idle(10); send(8'h40); send(8'h50); idle(2);
      // one short of the timeout keeps D1
      send(8'h92); send(8'h3C); idle(9); send(8'h41); idle(2);
      // SysEx timeout
      send(8'hF0); send(8'h11); idle(12); send(8'h22);
      // reset mid-message drops running status
      send(8'h92); send(8'h3C); step(1, 0, 8'h00); send(8'h40); send(8'h50); idle(2);
      // one-byte running status back to back
      send(8'hD2); send(8'h10); send(8'h11); send(8'h12); idle(2);

      // randomized stream
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         ch = ($urandom_range(0, 1) == 1) ? 4'(T_CHANNEL) : 4'($urandom_range(0, 15));
         if (r < 8)       idle($urandom_range(1, 12));
         else if (r < 18) send(8'($urandom_range(8'hF8, 8'hFF)));
         else if (r < 34) send({4'($urandom_range(8, 14)), ch});
         else if (r < 37) send(8'hF0);
         else if (r < 39) send(8'hF7);
         else if (r < 40) send(8'($urandom_range(8'hF1, 8'hF6)));
         else if (r < 41) step(1, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 127)));
         else             send(8'($urandom_range(0, 127)));
      end
      idle(15);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expected got=%0d pending exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/midi_message_parser.md
# midi_message_parser

Converts the raw MIDI byte stream from the UART receiver into complete channel-voice `message_t` records, each with a one-cycle `message_ready` strobe. It sits directly upstream of the recorder/dispatcher and is the only producer of `message`/`message_ready`. It handles running status, interleaved realtime bytes, SysEx skipping, channel filtering, NOTE_ON-velocity-0 normalisation and a stale-partial-message timeout.

## Interface
Parameters:
- `CHANNEL`, 0: MIDI channel (0–15) accepted when `OMNI`=0.
- `OMNI`, 1: 1 = accept all channels; 0 = accept only `CHANNEL`.
- `TIMEOUT_CYCLES`, 50_000_000: idle cycles after which a partial message is abandoned (1 s at 50 MHz); 0 disables.

Ports:
- `clock_50_000_000`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `byte_in`  in  8  received MIDI byte.
- `byte_ready`  in  1  one-cycle strobe; `byte_in` valid this cycle.
- `message`  out  `MIDI::message_t`  {message_type 4b = status high nibble, data_byte1 7b, data_byte2 7b}.
- `message_ready`  out  1  one-cycle strobe; `message` valid.
- `sysex_active`  out  1  high while SysEx data is being discarded.

## Operation
- State: IDLE, WAIT_D1, WAIT_D2, SYSEX. Registers: running status (valid bit, type nibble, channel nibble), held data_byte1, timeout counter.
- Bytes are processed only on cycles with `byte_ready`=1; otherwise state holds (except timeout).
- Status 0x80–0xEF (any state): latch type/channel, running status valid, → WAIT_D1; any partial data discarded.
- Status 0xF0: clear running status, → SYSEX. 0xF1–0xF7: clear running status, → IDLE (0xF7 also ends SYSEX).
- Realtime 0xF8–0xFF: ignored entirely in every state; no state, counter or running-status change.
- Data byte (bit7=0):
  - IDLE: running status valid → treat as D1 (below); else discarded.
  - WAIT_D1: two-byte types (0x8, 0x9, 0xA, 0xB, 0xE) store D1, → WAIT_D2. One-byte types (0xC, 0xD) complete with data_byte2=0, → IDLE.
  - WAIT_D2: complete with stored D1 and this byte, → IDLE (running status retained).
  - SYSEX: discarded.
- Completion: if channel accepted (`OMNI`=1 or channel==`CHANNEL`), register `message` and pulse `message_ready`; else drop silently (state still advances).
- NOTE_ON (0x9) with data_byte2=0 is emitted as NOTE_OFF with data_byte2=0.
- Timeout: counter clears on every non-realtime byte; increments each cycle in WAIT_D1/WAIT_D2/SYSEX; on reaching `TIMEOUT_CYCLES` → IDLE, running status retained except from SYSEX (already cleared).
- `sysex_active` = (state==SYSEX), registered.

## Timing
- Reset values: `message`='0, `message_ready`=0, `sysex_active`=0, state IDLE, running status invalid, counter 0.
- Latency: `message_ready` asserts the cycle after the `byte_ready` carrying the completing data byte; high exactly one cycle.
- `message` holds its value until the next emission; never changes without `message_ready`.
- Back-to-back `byte_ready` every cycle supported; max throughput one message per 2 bytes (1 byte for one-byte types with running status).
- No backpressure: downstream must accept every strobe.
- `reset` and `byte_ready` in same cycle: reset wins, byte lost.
- Reset mid-message: partial message and running status discarded; next data byte without status is dropped.
- Timeout and `byte_ready` in same cycle: byte is processed; timeout is not taken.

## Test plan
- Reset then 0x90,0x3C,0x64 → one `message_ready`, message={NOTE_ON,0x3C,0x64} the cycle after the third byte; outputs 0 during/after reset.
- Running status: 0x90,0x3C,0x64,0x3E,0x00 → {NOTE_ON,0x3C,0x64} then {NOTE_OFF,0x3E,0x00}.
- Realtime interleave: 0xB0,0xF8,0x40,0xFE,0x7F → single {CONTROL_CHANGE,0x40,0x7F}; state undisturbed.
- One-byte and SysEx: 0xC0,0x05 → {0xC,0x05,0x00}; then 0xF0,0x01,0x02,0xF7,0x10 → `sysex_active` high from cycle after 0xF0 until after 0xF7, no messages, trailing 0x10 dropped.
- Channel filter (`OMNI`=0,`CHANNEL`=2): 0x91,0x3C,0x64 → no strobe; 0x92,0x3C,0x64 → {NOTE_ON,0x3C,0x64}.
- Timeout (`TIMEOUT_CYCLES`=10): 0x90,0x3C, wait 10 cycles, 0x40,0x50 → single {NOTE_ON,0x40,0x50} (stale D1 abandoned, running status kept).
